// File: rtl/my6502_pkg.sv
// Constants and encodings shared across the 6502 video subsystem.
package my6502_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_DATA = 2'd2,
        C_ACK  = 2'd3
    } cpu_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Per-cycle grant between VGA fetch (priority, fixed latency) and CPU req/ack
// access to the single-port VRAM, with a wait limit that forces the CPU through.
//
// state  | meaning
// C_IDLE | no CPU access in flight; a new cpu_req may issue directly or be latched
// C_WAIT | request latched, losing to video; wait counter runs
// C_DATA | CPU access issued last cycle; ram_rdata is valid now
// C_ACK  | cpu_ack high; cpu_req ignored
module vram_arbiter
    import my6502_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    cpu_state_t        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_load;
    logic              forced, cpu_issue, grant_cpu, grant_vid, vid_drop;
    logic              tag_q;

    always_comb begin
        forced    = (state == C_WAIT) && (wait_cnt == WAIT_LIMIT);
        cpu_issue = ((state == C_IDLE) && cpu_req) || (state == C_WAIT);
        grant_cpu = forced || (cpu_issue && !vid_req);
        grant_vid = vid_req && !forced;
        vid_drop  = vid_req && forced;
    end

    // From C_IDLE the CPU bus is passed straight through so an uncontended
    // access issues in the same cycle it is seen.
    always_comb begin
        ram_addr  = vid_addr;
        ram_we    = 1'b0;
        ram_wdata = lat_wdata;
        if (grant_cpu) begin
            if (state == C_IDLE) begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we && !rst;
                ram_wdata = cpu_wdata;
            end else begin
                ram_addr  = lat_addr;
                ram_we    = lat_we && !rst;
                ram_wdata = lat_wdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        lat_load     = 1'b0;
        case (state)
            C_IDLE: begin
                if (cpu_req) begin
                    lat_load = 1'b1;
                    if (grant_cpu) begin
                        state_nxt = C_DATA;
                    end else begin
                        state_nxt    = C_WAIT;
                        wait_cnt_nxt = '0;
                    end
                end
            end
            C_WAIT: begin
                if (grant_cpu) begin
                    state_nxt    = C_DATA;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            C_DATA:  state_nxt = C_ACK;
            C_ACK:   state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= C_IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (lat_load) begin
                lat_addr  <= cpu_addr;
                lat_we    <= cpu_we;
                lat_wdata <= cpu_wdata;
            end
            cpu_ack <= (state == C_DATA);
            if ((state == C_DATA) && !lat_we) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    // Two-stage tag: grant -> ram_rdata capture -> vid_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            vid_miss  <= 1'b0;
        end else begin
            tag_q     <= grant_vid;
            vid_valid <= tag_q;
            if (tag_q) begin
                vid_data <= ram_rdata;
            end
            if (vid_drop) begin
                vid_miss <= 1'b1;
            end
        end
    end

endmodule
